// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/step/breakpoint controller for the single-cycle MIPS core. It drives the
// core-wide advance enable (cpu_en) that gates the PC, register-file and
// data-memory writes. It accepts HALT/RUN/STEP/CLEAR commands, and it halts
// the core on a PC breakpoint or on the all-zero end-of-program word. It also
// keeps saturating performance counters.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake (ready is always 1)
//   cmd_op, cmd_arg   00 HALT, 01 RUN, 10 STEP, 11 CLEAR; step count for STEP
//   cmd_err           one-cycle pulse: RUN/STEP received while not halted
//   bp_en, bp_addr    PC breakpoint
//   pc, instr         current core PC and fetched instruction
//   branch_taken, jump, jump_reg   core event flags for this cycle
//   cpu_en            core advance enable (combinational)
//   state             00 HALT, 01 RUN, 10 STEP
//   halt_cause        0 cmd/reset, 1 step done, 2 breakpoint, 3 null instr
//   cycle_cnt, branch_cnt, jump_cnt, jr_cnt   saturating counters
module cpu_run_ctrl #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    output logic              cmd_err,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    input  logic [31:0]       instr,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              jump_reg,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  jump_cnt,
    output logic [CNT_W-1:0]  jr_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_HALT  = 2'b00,
        OP_RUN   = 2'b01,
        OP_STEP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        CAUSE_CMD  = 2'd0,
        CAUSE_STEP = 2'd1,
        CAUSE_BP   = 2'd2,
        CAUSE_NULL = 2'd3
    } cause_t;

    state_t            state_q, state_d;
    cause_t            cause_q, cause_d;
    logic [STEP_W-1:0] step_rem_q, step_rem_d;
    logic              bp_skip_q, bp_skip_d;
    logic              cmd_err_q, cmd_err_d;

    logic bp_hit;
    logic null_hit;
    logic stop;
    logic active;
    logic cmd_halt, cmd_run, cmd_step, cmd_clear;

    // Stop detection and core enable
    always_comb begin
        bp_hit   = bp_en && (pc == bp_addr) && !bp_skip_q;
        null_hit = (instr == '0);
        stop     = bp_hit || null_hit;
        active   = (state_q == ST_RUN) || (state_q == ST_STEP);
        cpu_en   = active && !stop;
    end

    always_comb begin
        cmd_halt  = cmd_valid && (cmd_op == OP_HALT);
        cmd_run   = cmd_valid && (cmd_op == OP_RUN);
        cmd_step  = cmd_valid && (cmd_op == OP_STEP);
        cmd_clear = cmd_valid && (cmd_op == OP_CLEAR);
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        step_rem_d = step_rem_q;
        bp_skip_d  = bp_skip_q;
        cmd_err_d  = 1'b0;

        // The breakpoint mask only needs to cover the one instruction at the
        // breakpoint PC, so it clears once the core has advanced.
        if (cpu_en) begin
            bp_skip_d = 1'b0;
        end
        if (cpu_en && (state_q == ST_STEP)) begin
            step_rem_d = step_rem_q - STEP_W'(1);
        end

        unique case (state_q)
            ST_HALT: begin
                if (cmd_run) begin
                    state_d   = ST_RUN;
                    bp_skip_d = (cause_q == CAUSE_BP);
                end else if (cmd_step) begin
                    state_d    = ST_STEP;
                    step_rem_d = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
                    bp_skip_d  = (cause_q == CAUSE_BP);
                end
            end
            ST_RUN, ST_STEP: begin
                cmd_err_d = cmd_run || cmd_step;
                if (stop) begin
                    state_d = ST_HALT;
                    cause_d = null_hit ? CAUSE_NULL : CAUSE_BP;
                end else if (cmd_halt) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_CMD;
                end else if ((state_q == ST_STEP) && (step_rem_q == STEP_W'(1))) begin
                    // Reaching here implies cpu_en=1: active and not stopped.
                    state_d = ST_HALT;
                    cause_d = CAUSE_STEP;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HALT;
            cause_q    <= CAUSE_CMD;
            step_rem_q <= '0;
            bp_skip_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            step_rem_q <= step_rem_d;
            bp_skip_q  <= bp_skip_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // Performance counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic            en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt  <= '0;
            branch_cnt <= '0;
            jump_cnt   <= '0;
            jr_cnt     <= '0;
        end else if (cmd_clear) begin
            cycle_cnt  <= '0;
            branch_cnt <= '0;
            jump_cnt   <= '0;
            jr_cnt     <= '0;
        end else if (cpu_en) begin
            cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
            branch_cnt <= sat_inc(branch_cnt, branch_taken);
            jump_cnt   <= sat_inc(jump_cnt, jump);
            jr_cnt     <= sat_inc(jr_cnt, jump_reg);
        end
    end

    assign cmd_ready  = 1'b1;
    assign cmd_err    = cmd_err_q;
    assign state      = state_q;
    assign halt_cause = cause_q;

endmodule
